gb_cpu_mem_bridge: RTL and testbench
====================================

// Module: gb_cpu_mem_bridge
// PURPOSE
//  Downstream of the tv80s CPU wrapper. Converts the CPU strobe bus (mreq_n/iorq_n/rd_n/wr_n, A, do)
//  into a single req/ack handshake toward a variable-latency memory port (SRAM/ROM/IO mux).
//  Holds the CPU with wait_n and returns read data on di.
//  Also answers interrupt-acknowledge cycles with an externally supplied vector byte.
// PARAMETERS
//  TIMEOUT    255    BUSY cycles without mem_ack before the access is aborted (1..255)
//  IDLE_DATA  8'hFF  value returned on abort; also the cpu_din reset value
// PORTS
//  clk         in   1   clock, all logic on posedge
//  reset_n     in   1   synchronous, active-low reset
//  cpu_m1_n    in   1   CPU m1_n
//  cpu_mreq_n  in   1   CPU mreq_n
//  cpu_iorq_n  in   1   CPU iorq_n
//  cpu_rd_n    in   1   CPU rd_n
//  cpu_wr_n    in   1   CPU wr_n
//  cpu_addr    in   16  CPU address A
//  cpu_dout    in   8   CPU write data (do)
//  cpu_din     out  8   read data to CPU di
//  cpu_wait_n  out  1   wait to CPU, combinational from state and strobes
//  int_vector  in   8   byte returned on interrupt acknowledge
//  mem_req     out  1   memory request, held until ack or abort
//  mem_we      out  1   1 = write, 0 = read; valid while mem_req
//  mem_addr    out  16  latched address; valid while mem_req
//  mem_wdata   out  8   latched write data; valid while mem_req
//  mem_ack     in   1   completion, sampled only while mem_req=1
//  mem_rdata   in   8   read data, valid with mem_ack
//  timeout_err out  1   one-cycle pulse on abort
// BEHAVIOUR
//  Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_din=IDLE_DATA, timeout_err=0.
//   State resets to IDLE. cpu_wait_n=1 while strobes are inactive.
//  Decode:
//   mem_acc = !mreq_n & (!rd_n | !wr_n). Write wins if rd_n and wr_n are both low.
//   int_ack = !m1_n & !iorq_n & !rd_n.
//   iorq_n cycles without m1_n are ignored: no req, wait_n=1, cpu_din unchanged.
//  States IDLE / BUSY / DONE:
//   IDLE & mem_acc: cpu_wait_n=0 in the same cycle. At the edge, latch addr/dout/we,
//    set mem_req=1, clear counter, go BUSY.
//   IDLE & int_ack: cpu_din = int_vector combinationally, wait_n=1.
//    At the edge, register int_vector into cpu_din and go DONE. No mem_req.
//   BUSY: cpu_wait_n=0.
//    - mem_ack=1 at an edge: mem_req<=0; cpu_din<=mem_rdata on reads, unchanged on writes; go DONE.
//    - Else counter+1. Counter==TIMEOUT-1 at an edge: mem_req<=0, cpu_din<=IDLE_DATA,
//      timeout_err<=1 for one cycle, go DONE.
//   DONE: cpu_wait_n=1, cpu_din held. Go IDLE at the first edge where !mem_acc & !int_ack.
//    A new access needs at least one inactive-strobe cycle, so a held strobe never re-triggers.
//  Latency: wait_n is low for 1 + (BUSY cycles up to and including ack). Minimum 2 cycles.
//  mem_ack while mem_req=0 is ignored. mem_addr/we/wdata stay stable from req rise to ack.
//  Reset mid-access: the next edge forces IDLE, mem_req=0, counter=0, cpu_din=IDLE_DATA.
//   The memory side must tolerate the abandoned request.
//  Counter width: 8 bits.
// STRUCTURE
//  Shared package gb_bus_pkg:
//   bridge_state_t enum {IDLE, BUSY, DONE}; GB_IDLE_DATA=8'hFF; function decode_mem_acc().
//  Single module. No sub-module: the timeout counter is inline.
// TESTING
//  1 Read 0x0150, ack 3 cycles after mem_req, rdata 0xC3 -> mem_req high 3 cycles,
//    mem_we=0, wait_n low 4 cycles, cpu_din=0xC3.
//  2 Write 0xFF80 data 0x5A, ack in first BUSY cycle -> mem_we=1, mem_wdata=0x5A,
//    wait_n low exactly 2 cycles.
//  3 Int ack (m1_n=0, iorq_n=0, rd_n=0), int_vector=0x40 -> no mem_req, wait_n stays 1,
//    cpu_din=0x40 in the same cycle.
//  4 TIMEOUT=8, never ack -> mem_req falls after 8 BUSY cycles, timeout_err one pulse,
//    cpu_din=0xFF, CPU released.
//  5 reset_n=0 during BUSY -> next cycle mem_req=0, wait_n=1, cpu_din=0xFF.
//    The next read then completes normally.
//  6 Back-to-back reads with strobe held 2 cycles in DONE plus a spurious mem_ack in IDLE ->
//    exactly one mem_req per access, no extra request.

Source files
------------

// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg: shared bus types, constants and strobe decode for the CPU memory bridge
package gb_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} bridge_state_t;
  localparam logic [7:0] GB_IDLE_DATA = 8'hFF;
  function automatic logic decode_mem_acc(input logic mreq_n, input logic rd_n, input logic wr_n);
    return !mreq_n & (!rd_n | !wr_n);
  endfunction
endpackage

// File: rtl/gb_cpu_mem_bridge.sv
// gb_cpu_mem_bridge: CPU strobe bus to req/ack memory port with wait insertion, timeout and int-ack vector
module gb_cpu_mem_bridge
  import gb_bus_pkg::*;
#(
  parameter logic [7:0] TIMEOUT   = 8'd255,
  parameter logic [7:0] IDLE_DATA = GB_IDLE_DATA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_m1_n,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_wait_n,
  input  logic [7:0]  int_vector,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        timeout_err
);
  bridge_state_t state, state_nx;
  logic [7:0] cnt, din_q;
  logic mem_acc, int_ack, tmo;
  assign mem_acc = decode_mem_acc(cpu_mreq_n, cpu_rd_n, cpu_wr_n);
  assign int_ack = !cpu_m1_n & !cpu_iorq_n & !cpu_rd_n;
  assign tmo     = cnt == TIMEOUT - 8'd1;
  // next state, CPU wait and the combinational int-ack vector bypass
  always_comb begin
    state_nx   = state;
    cpu_wait_n = 1'b1;
    cpu_din    = din_q;
    case (state)
      IDLE: begin
        if (mem_acc) begin
          cpu_wait_n = 1'b0;
          state_nx   = BUSY;
        end else if (int_ack) begin
          cpu_din  = int_vector;
          state_nx = DONE;
        end
      end
      BUSY: begin
        cpu_wait_n = 1'b0;
        state_nx   = (mem_ack || tmo) ? DONE : BUSY;
      end
      DONE: state_nx = (!mem_acc && !int_ack) ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // memory request, latched access fields, read data and timeout counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      din_q       <= IDLE_DATA;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_acc) begin
            mem_req   <= 1'b1;
            mem_we    <= !cpu_wr_n;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_dout;
            cnt       <= '0;
          end else if (int_ack) begin
            din_q <= int_vector;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) din_q <= mem_rdata;
          end else if (tmo) begin
            mem_req     <= 1'b0;
            din_q       <= IDLE_DATA;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gb_cpu_mem_bridge.sv
// tb_gb_cpu_mem_bridge: directed checks of the CPU memory bridge with hand-computed expectations
module tb_gb_cpu_mem_bridge;
  logic clk = 1'b0, reset_n = 1'b0;
  logic cpu_m1_n = 1'b1, cpu_mreq_n = 1'b1, cpu_iorq_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_dout = '0, int_vector = '0, mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic [7:0] cpu_din, mem_wdata;
  logic cpu_wait_n, mem_req, mem_we, timeout_err;
  logic [15:0] mem_addr;
  int tests = 0, fails = 0, req_rises = 0;
  logic req_prev = 1'b0;
  int rc, wc, ec, bad, r0;
  logic we_s;
  logic [7:0] wd_s;
  gb_cpu_mem_bridge #(.TIMEOUT(8'd8), .IDLE_DATA(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_m1_n(cpu_m1_n), .cpu_mreq_n(cpu_mreq_n),
    .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_wait_n(cpu_wait_n), .int_vector(int_vector),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    req_prev <= mem_req;
    if (mem_req && !req_prev) req_rises <= req_rises + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic release_bus();
    {cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n} = 5'b11111;
    step();
  endtask
  task automatic access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                        input int ack_at, input logic [7:0] rd);
    logic done = 1'b0;
    cpu_mreq_n = 1'b0; cpu_rd_n = wr; cpu_wr_n = !wr; cpu_addr = a; cpu_dout = d;
    #1;
    rc = 0; wc = 0; ec = 0; bad = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (cpu_wait_n) done = 1'b1;
      else begin
        wc++;
        if (mem_req) begin
          rc++;
          if (rc == 1) begin we_s = mem_we; wd_s = mem_wdata; end
          if (mem_addr !== a || mem_we !== wr || mem_wdata !== d) bad++;
          mem_ack = (rc == ack_at);
          mem_rdata = rd;
        end
        step();
        mem_ack = 1'b0;
        if (timeout_err) ec++;
      end
    end
    chk("access_bound", done, 1'b1);
  endtask
  initial begin
    step(); step();
    chk("rst_req", mem_req, 0);
    chk("rst_wait", cpu_wait_n, 1);
    chk("rst_din", cpu_din, 8'hFF);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", timeout_err, 0);
    reset_n = 1'b1;
    step();
    // 1: read with ack in third BUSY cycle
    access(1'b0, 16'h0150, 8'h00, 3, 8'hC3);
    chk("t1_req_cyc", rc, 3);
    chk("t1_wait_cyc", wc, 4);
    chk("t1_we", we_s, 0);
    chk("t1_stable", bad, 0);
    chk("t1_din", cpu_din, 8'hC3);
    release_bus();
    // 2: write acked in first BUSY cycle, read data untouched
    access(1'b1, 16'hFF80, 8'h5A, 1, 8'hEE);
    chk("t2_wait_cyc", wc, 2);
    chk("t2_we", we_s, 1);
    chk("t2_wdata", wd_s, 8'h5A);
    chk("t2_din_kept", cpu_din, 8'hC3);
    release_bus();
    // 3: interrupt acknowledge
    int_vector = 8'h40; cpu_m1_n = 1'b0; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    chk("t3_din_comb", cpu_din, 8'h40);
    chk("t3_wait", cpu_wait_n, 1);
    step();
    int_vector = 8'h11;
    #1;
    chk("t3_din_held", cpu_din, 8'h40);
    chk("t3_no_req", mem_req, 0);
    release_bus();
    // io cycle without m1 is ignored
    cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    chk("io_wait", cpu_wait_n, 1);
    step();
    chk("io_no_req", mem_req, 0);
    chk("io_din", cpu_din, 8'h40);
    release_bus();
    // 4: timeout after 8 BUSY cycles
    access(1'b0, 16'h1234, 8'h00, 0, 8'h00);
    chk("t4_req_cyc", rc, 8);
    chk("t4_wait_cyc", wc, 9);
    chk("t4_err_pulses", ec, 1);
    chk("t4_din", cpu_din, 8'hFF);
    chk("t4_req_low", mem_req, 0);
    step();
    chk("t4_err_one", timeout_err, 0);
    release_bus();
    // 5: reset during BUSY, then a normal read
    access(1'b0, 16'h0042, 8'h00, 1, 8'h77);
    chk("t5_pre_din", cpu_din, 8'h77);
    release_bus();
    cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_addr = 16'h0300;
    step(); step();
    chk("t5_busy_req", mem_req, 1);
    reset_n = 1'b0;
    {cpu_mreq_n, cpu_rd_n} = 2'b11;
    step();
    chk("t5_rst_req", mem_req, 0);
    chk("t5_rst_wait", cpu_wait_n, 1);
    chk("t5_rst_din", cpu_din, 8'hFF);
    reset_n = 1'b1;
    step();
    access(1'b0, 16'h2000, 8'h00, 2, 8'h9E);
    chk("t5_wait_cyc", wc, 3);
    chk("t5_din", cpu_din, 8'h9E);
    release_bus();
    // 6: held strobe in DONE and spurious acks must not create requests
    r0 = req_rises;
    access(1'b0, 16'h0A00, 8'h00, 1, 8'h11);
    mem_ack = 1'b1;
    step(); step();
    chk("t6_held_req", mem_req, 0);
    chk("t6_held_wait", cpu_wait_n, 1);
    {cpu_mreq_n, cpu_rd_n} = 2'b11;
    step(); step();
    chk("t6_idle_ack_req", mem_req, 0);
    mem_ack = 1'b0;
    access(1'b0, 16'h0A01, 8'h00, 2, 8'h22);
    chk("t6_din", cpu_din, 8'h22);
    release_bus();
    step();
    chk("t6_req_count", req_rises - r0, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
